// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer for the iCE40 USB clock PLL.
// Pulses the PLL reset, waits for lock, filters lock for a programmable time,
// then releases the USB core reset. It retries on lock timeout, re-sequences
// on lock loss, and parks in a sticky fault after too many failed attempts.
module pll_lock_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 12,
    parameter int unsigned LOCK_TIMEOUT   = 120000,
    parameter int unsigned LOCK_FILTER    = 1200,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned CNT_W          = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       clear_fault,
    output logic       pll_resetb,
    output logic       core_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] relock_count
);

    // Terminal counts: each phase ends on the cycle its counter reads N-1.
    localparam logic [CNT_W-1:0] RstLast    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FilterLast = CNT_W'(LOCK_FILTER - 1);
    localparam logic [3:0]       RetryMax   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StFilter,
        StRun,
        StFault
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retries_q, retries_d;
    logic [7:0]       relock_q, relock_d;
    logic [1:0]       sync_q, sync_d;
    logic             lock_s;

    logic pll_resetb_q, pll_resetb_d;
    logic core_rst_q, core_rst_d;
    logic ready_q, ready_d;
    logic fault_q, fault_d;

    // Two-stage synchroniser for the asynchronous LOCK pin.
    always_comb begin
        sync_d = {sync_q[0], pll_lock};
    end

    assign lock_s = sync_q[1];

    // Sequencing decisions: phase counter, retry budget and relock statistics.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        relock_d  = relock_q;

        case (state_q)
            StPllRst: begin
                if (cnt_q == RstLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StWaitLock: begin
                // Lock seen on the timeout cycle still counts as success.
                if (lock_s) begin
                    state_d = StFilter;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d = '0;
                    if (retries_q == RetryMax) begin
                        state_d = StFault;
                    end else begin
                        retries_d = retries_q + 4'd1;
                        state_d   = StPllRst;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StFilter: begin
                // A dropout restarts the lock wait without consuming a retry.
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == FilterLast) begin
                    state_d   = StRun;
                    cnt_d     = '0;
                    retries_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StRun: begin
                if (!lock_s) begin
                    state_d   = StPllRst;
                    cnt_d     = '0;
                    retries_d = '0;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end
            end

            StFault: begin
                if (clear_fault) begin
                    state_d   = StPllRst;
                    cnt_d     = '0;
                    retries_d = '0;
                end
            end

            default: begin
                state_d   = StPllRst;
                cnt_d     = '0;
                retries_d = '0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track state_q.
    always_comb begin
        pll_resetb_d = 1'b1;
        core_rst_d   = 1'b1;
        ready_d      = 1'b0;
        fault_d      = 1'b0;

        case (state_d)
            StPllRst: begin
                pll_resetb_d = 1'b0;
            end
            StWaitLock, StFilter: begin
                pll_resetb_d = 1'b1;
            end
            StRun: begin
                core_rst_d = 1'b0;
                ready_d    = 1'b1;
            end
            StFault: begin
                pll_resetb_d = 1'b0;
                fault_d      = 1'b1;
            end
            default: begin
                pll_resetb_d = 1'b0;
            end
        endcase
    end

    // All state, including the registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StPllRst;
            cnt_q        <= '0;
            retries_q    <= '0;
            relock_q     <= '0;
            sync_q       <= '0;
            pll_resetb_q <= 1'b0;
            core_rst_q   <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retries_q    <= retries_d;
            relock_q     <= relock_d;
            sync_q       <= sync_d;
            pll_resetb_q <= pll_resetb_d;
            core_rst_q   <= core_rst_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_resetb   = pll_resetb_q;
    assign core_rst     = core_rst_q;
    assign ready        = ready_q;
    assign fault        = fault_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: vector table, hand-written corner sequences,
// and a randomized run against a phase/elapsed-time reference model.
// Cycle k means the interval between edge k-1 and edge k, where edge 0 is the
// first rising edge sampling rst=0; inputs for cycle k are sampled at edge k.
module tb_pll_lock_sequencer;

    localparam int unsigned RstC  = 3;
    localparam int unsigned ToC   = 16;
    localparam int unsigned FiltC = 4;
    localparam int unsigned MaxR  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       clear_fault = 1'b0;
    logic       pll_resetb;
    logic       core_rst;
    logic       ready;
    logic       fault;
    logic [7:0] relock_count;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES(RstC),
        .LOCK_TIMEOUT  (ToC),
        .LOCK_FILTER   (FiltC),
        .MAX_RETRIES   (MaxR),
        .CNT_W         (17)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .clear_fault (clear_fault),
        .pll_resetb  (pll_resetb),
        .core_rst    (core_rst),
        .ready       (ready),
        .fault       (fault),
        .relock_count(relock_count)
    );

    // Reference model: which phase we are in and how long we have been there.
    typedef enum int {MPulse, MAwait, MQualify, MOperate, MFailed} mphase_e;
    mphase_e m_phase    = MPulse;
    int      m_spent    = 0;
    int      m_timeouts = 0;
    int      m_relocks  = 0;
    bit      m_pipe[$]  = '{1'b0, 1'b0};

    task automatic m_enter(input mphase_e p);
        m_phase = p;
        m_spent = 0;
    endtask

    task automatic model_edge();
        bit ls;
        ls = m_pipe[0];
        void'(m_pipe.pop_front());
        m_pipe.push_back(pll_lock);
        if (rst) begin
            m_pipe     = '{1'b0, 1'b0};
            m_timeouts = 0;
            m_relocks  = 0;
            m_enter(MPulse);
            return;
        end
        m_spent++;
        case (m_phase)
            MPulse:   if (m_spent >= int'(RstC)) m_enter(MAwait);
            MAwait: begin
                if (ls) m_enter(MQualify);
                else if (m_spent >= int'(ToC)) begin
                    if (m_timeouts == int'(MaxR)) m_enter(MFailed);
                    else begin
                        m_timeouts++;
                        m_enter(MPulse);
                    end
                end
            end
            MQualify: begin
                if (!ls) m_enter(MAwait);
                else if (m_spent >= int'(FiltC)) begin
                    m_timeouts = 0;
                    m_enter(MOperate);
                end
            end
            MOperate: begin
                if (!ls) begin
                    if (m_relocks < 255) m_relocks++;
                    m_timeouts = 0;
                    m_enter(MPulse);
                end
            end
            MFailed: begin
                if (clear_fault) begin
                    m_timeouts = 0;
                    m_enter(MPulse);
                end
            end
            default: m_enter(MPulse);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic e_rb, input logic e_cr,
                         input logic e_rd, input logic e_ft, input logic [7:0] e_rc);
        n_vec++;
        if ({pll_resetb, core_rst, ready, fault, relock_count} !==
            {e_rb, e_cr, e_rd, e_ft, e_rc}) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got resetb=%b core_rst=%b ready=%b fault=%b relock=%0d, want resetb=%b core_rst=%b ready=%b fault=%b relock=%0d",
                     name, cyc, pll_resetb, core_rst, ready, fault, relock_count,
                     e_rb, e_cr, e_rd, e_ft, e_rc);
        end
    endtask

    task automatic do_reset(input logic lvl);
        rst         = 1'b1;
        clear_fault = 1'b0;
        pll_lock    = lvl;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    typedef struct {
        logic       lock;
        logic       exp_rb;
        logic       exp_cr;
        logic       exp_rd;
        logic       exp_ft;
        logic [7:0] exp_rc;
    } vec_t;

    vec_t t1[12];

    initial begin
        int   seg;
        logic rb, rd, ft;

        // Lock tied high: 3-cycle PLL reset, FILTER 4..7, RUN from 8.
        t1[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        t1[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        t1[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        t1[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        t1[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        t1[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        t1[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        t1[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        t1[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        t1[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        t1[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        t1[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};

        do_reset(1'b1);
        for (int i = 0; i < 12; i++) begin
            pll_lock = t1[i].lock;
            check("t1_table", t1[i].exp_rb, t1[i].exp_cr, t1[i].exp_rd, t1[i].exp_ft,
                  t1[i].exp_rc);
            tick();
        end

        // Lock never comes: three attempts, fault at 57, cleared at 70.
        do_reset(1'b0);
        for (int k = 0; k <= 80; k++) begin
            pll_lock    = 1'b0;
            clear_fault = (k == 70);
            rb = !(k <= 2 || (k >= 19 && k <= 21) || (k >= 38 && k <= 40) ||
                   (k >= 57 && k <= 73));
            ft = (k >= 57 && k <= 70);
            check("t2_timeout_fault", rb, 1'b1, 1'b0, ft, 8'd0);
            tick();
        end
        clear_fault = 1'b0;

        // One-cycle dropout during FILTER: back to WAIT_LOCK, RUN delayed to 12.
        do_reset(1'b1);
        for (int k = 0; k <= 15; k++) begin
            pll_lock = (k != 4);
            rd = (k >= 12);
            check("t3_filter_drop", (k >= 3), !rd, rd, 1'b0, 8'd0);
            tick();
        end

        // Lock loss in RUN at cycle 20, lock back after two cycles.
        do_reset(1'b1);
        for (int k = 0; k <= 34; k++) begin
            pll_lock = !(k == 20 || k == 21);
            rd = (k >= 8 && k < 23) || (k >= 31);
            rb = !(k <= 2 || (k >= 23 && k <= 25));
            check("t4_lock_loss", rb, !rd, rd, 1'b0, (k >= 23) ? 8'd1 : 8'd0);
            tick();
        end

        // 300 lock-loss events, then reset asserted mid-FILTER.
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) begin
            pll_lock = 1'b1;
            if (k == 9) check("t5_run_start", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
            tick();
        end
        for (int e = 0; e < 300; e++) begin
            for (int j = 0; j < 13; j++) begin
                pll_lock = (j >= 2);
                if (j == 12)
                    check("t5_relock_sat", 1'b1, 1'b0, 1'b1, 1'b0,
                          8'((e + 1 > 255) ? 255 : e + 1));
                tick();
            end
        end
        for (int j = 0; j <= 9; j++) begin
            pll_lock = (j >= 2);
            if (j == 8) begin
                check("t5_in_filter", 1'b1, 1'b1, 1'b0, 1'b0, 8'd255);
                rst = 1'b1;
            end
            if (j == 9) begin
                check("t5_rst_mid_filter", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
                rst = 1'b0;
            end
            tick();
        end
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) check("t5_run_after_rst", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
            tick();
        end

        // Lock on attempt 2, then loss and repeated timeouts: retries were cleared.
        do_reset(1'b0);
        for (int k = 0; k <= 100; k++) begin
            pll_lock = (k >= 22 && k < 32);
            rd = (k >= 29 && k <= 34);
            ft = (k >= 92);
            rb = !(k <= 2 || (k >= 19 && k <= 21) || (k >= 35 && k <= 37) ||
                   (k >= 54 && k <= 56) || (k >= 73 && k <= 75) || k >= 92);
            check("t6_retry_budget", rb, !rd, rd, ft, (k >= 35) ? 8'd1 : 8'd0);
            tick();
        end

        // lock_s rises on the very timeout cycle: lock wins.
        do_reset(1'b0);
        for (int k = 0; k <= 24; k++) begin
            pll_lock = (k >= 16);
            rd = (k >= 23);
            check("t7_lock_on_timeout", (k >= 3), !rd, rd, 1'b0, 8'd0);
            tick();
        end

        // Randomized run against the reference model.
        do_reset(1'b0);
        seg = 0;
        for (int k = 0; k < 6000; k++) begin
            if (seg == 0) begin
                pll_lock = ($urandom_range(0, 1) == 1);
                seg = pll_lock ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 70));
            end
            seg--;
            clear_fault = ($urandom_range(0, 9) == 0);
            rst         = ($urandom_range(0, 499) == 0);
            check("random",
                  !(m_phase == MPulse || m_phase == MFailed),
                  m_phase != MOperate,
                  m_phase == MOperate,
                  m_phase == MFailed,
                  8'(m_relocks));
            tick();
        end
        rst         = 1'b0;
        clear_fault = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Runs in the PLL reference-clock domain (12 MHz board clock) and sequences bring-up of the iCE40 PLL that generates the 60 MHz USB clock.
- Drives the PLL's RESETB pin, qualifies the asynchronous LOCK output, and holds the USB core in reset until lock has been stable for a programmable time.
- Retries the PLL on lock timeout, re-sequences on lock loss, and raises a sticky fault after repeated failures.

Parameters:
- PLL_RST_CYCLES, 12, cycles pll_resetb is held low per attempt (≥1).
- LOCK_TIMEOUT, 120000, cycles to wait for first lock_s high per attempt (10 ms at 12 MHz, ≥2).
- LOCK_FILTER, 1200, consecutive lock_s-high cycles required before release (100 µs, ≥1).
- MAX_RETRIES, 3, extra attempts after the first timeout before FAULT (0..15).
- CNT_W, 17, counter width; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_FILTER)-1.

Ports:
- clk, in, 1, reference clock, also PLL REFERENCECLK.
- rst, in, 1, synchronous active-high reset.
- pll_lock, in, 1, PLL LOCK output, asynchronous to clk.
- clear_fault, in, 1, single-cycle pulse; leaves FAULT.
- pll_resetb, out, 1, to PLL RESETB, active low.
- core_rst, out, 1, reset request to the 60 MHz domain; the consumer resynchronises deassertion.
- ready, out, 1, high only in RUN.
- fault, out, 1, high only in FAULT.
- relock_count, out, 8, number of RUN→lock-loss events, saturating at 255.

Behaviour:
- Synchroniser: 2-flop on pll_lock → lock_s; both flops reset to 0. Latency is 2 clk.
- Moore outputs, decoded from the registered state:
  - PLL_RST: pll_resetb=0, core_rst=1.
  - WAIT_LOCK, FILTER: pll_resetb=1, core_rst=1.
  - RUN: pll_resetb=1, core_rst=0, ready=1.
  - FAULT: pll_resetb=0, core_rst=1, fault=1.
- Reset values: state=PLL_RST, cnt=0, retries=0, relock_count=0. Outputs are therefore pll_resetb=0, core_rst=1, ready=0, fault=0. rst in any state, including mid-FILTER or RUN, returns here within 1 cycle.
- PLL_RST:
  - cnt increments each cycle.
  - When cnt==PLL_RST_CYCLES-1: go to WAIT_LOCK, cnt=0. Duration is exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - If lock_s=1: go to FILTER, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1 (timeout):
    - retries==MAX_RETRIES: go to FAULT.
    - Otherwise: retries+=1, go to PLL_RST, cnt=0.
  - Else cnt+=1.
  - lock_s high on the timeout cycle wins over the timeout.
- FILTER:
  - If lock_s=0: go to WAIT_LOCK, cnt=0. This is not a retry; the timeout restarts.
  - Else if cnt==LOCK_FILTER-1: go to RUN, retries=0.
  - Else cnt+=1.
- RUN:
  - If lock_s=0: relock_count+=1 (saturating), go to PLL_RST, cnt=0, retries=0.
  - core_rst rises at most 3 clk after pll_lock falls.
- FAULT:
  - Held until clear_fault=1, then go to PLL_RST, cnt=0, retries=0.
  - clear_fault is ignored in all other states.
  - relock_count is kept across FAULT; only rst clears it.
- Counter arithmetic is unsigned CNT_W bits. Comparisons use full width; no wrap is possible given the parameter limits.
- The retries register is 4 bits.

Test Plan:
Bench parameters: PLL_RST_CYCLES=3, LOCK_TIMEOUT=16, LOCK_FILTER=4, MAX_RETRIES=2. Cycle 0 is the first edge with rst=0.
1. pll_lock tied 1 → pll_resetb=0 for cycles 0–2 and 1 from cycle 3. FILTER covers cycles 4–7. core_rst falls and ready rises at cycle 8. fault=0 and relock_count=0 throughout.
2. pll_lock tied 0 → three PLL_RST pulses of 3 cycles, each followed by a 16-cycle WAIT_LOCK. fault rises at cycle 57 with pll_resetb=0 and core_rst=1. Pulsing clear_fault at cycle 70 gives pll_resetb=0 for cycles 71–73 and a fresh sequence.
3. Test 1 flow, but pll_lock drops for 1 cycle during FILTER (lock_s low at cycle 6) → return to WAIT_LOCK, no retry counted, FILTER restarts. ready is delayed accordingly and never glitches high.
4. In RUN, pll_lock falls at cycle N → core_rst=1 and ready=0 by cycle N+3, pll_resetb=0 for 3 cycles, relock_count=1. With pll_lock returned high, ready is back 8 cycles after PLL_RST entry.
5. 300 lock-loss events in RUN → relock_count saturates at 255. Asserting rst mid-FILTER → next cycle shows reset values and relock_count=0.
6. Lock first asserts in attempt 2, then RUN, then lock loss and timeout twice → full MAX_RETRIES budget is available again. FAULT only occurs after the 3rd consecutive timeout, which confirms retries was cleared in RUN.
